// File: rtl/bcd_mod_counter_if.sv
// rtl/bcd_mod_counter_if.sv - Control/status bundle for bcd_mod_counter
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  dir;
  logic [4*DIGITS-1:0]   data;
  logic                  co;
  logic                  tc;
  logic                  load_err;

  modport master (
    output en, clr, load, load_val, dir,
    input  data, co, tc, load_err
  );

  modport slave (
    input  en, clr, load, load_val, dir,
    output data, co, tc, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - Packed-BCD modulo counter with preset; down counting enabled by BCD_DOWN_EN
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic              clk,
  input  logic              rst,
  bcd_mod_counter_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0] data_q, data_d, inc_val;
  logic         co_q, co_d, err_q, err_d;
  logic         at_max, load_ok, carry;

  assign at_max = (data_q == MAX_BCD);

  always_comb begin
    inc_val = data_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (data_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = data_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // With every digit <= 9, packed BCD orders the same as its decimal value
  always_comb begin
    load_ok = (bus.load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

`ifdef BCD_DOWN_EN
  logic [W-1:0] dec_val;
  logic         at_zero, borrow;

  assign at_zero = (data_q == '0);

  always_comb begin
    dec_val = data_q;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (data_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = data_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  assign bus.tc = bus.en & (bus.dir ? at_zero : at_max);
`else
  logic unused_dir;
  assign unused_dir = bus.dir;
  assign bus.tc     = bus.en & at_max;
`endif

  always_comb begin
    data_d = data_q;
    co_d   = 1'b0;
    err_d  = 1'b0;
    if (bus.clr) begin
      data_d = '0;
    end else if (bus.load) begin
      if (load_ok) data_d = bus.load_val;
      else         err_d  = 1'b1;
    end else if (bus.en) begin
`ifdef BCD_DOWN_EN
      if (bus.dir) begin
        if (at_zero) begin
          data_d = MAX_BCD;
          co_d   = 1'b1;
        end else begin
          data_d = dec_val;
        end
      end else
`endif
      begin
        if (at_max) begin
          data_d = '0;
          co_d   = 1'b1;
        end else begin
          data_d = inc_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      co_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      co_q   <= co_d;
      err_q  <= err_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.co       = co_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - Self-checking bench for bcd_mod_counter (mod 60, mod 24, cascaded 60x60)
module tb_bcd_mod_counter;
  logic clk;
  logic rst;

`ifdef BCD_DOWN_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif

  bcd_mod_counter_if #(.DIGITS(2)) if60 ();
  bcd_mod_counter_if #(.DIGITS(2)) if24 ();
  bcd_mod_counter_if #(.DIGITS(2)) sec_if ();
  bcd_mod_counter_if #(.DIGITS(2)) min_if ();

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u60   (.clk(clk), .rst(rst), .bus(if60));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u24   (.clk(clk), .rst(rst), .bus(if24));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_sec (.clk(clk), .rst(rst), .bus(sec_if));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_min (.clk(clk), .rst(rst), .bus(min_if));

  assign min_if.en = sec_if.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count held as a plain integer 0..modulus-1
  typedef struct packed {
    logic [31:0] v;
    logic        co;
    logic        err;
  } mstate_t;

  function automatic logic [7:0] to_bcd8(input logic [31:0] v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int modulus, input logic r,
                                    input logic clr, input logic load, input logic [7:0] lv,
                                    input logic en, input logic dir);
    mstate_t n;
    int hi, lo;
    n     = s;
    n.co  = 1'b0;
    n.err = 1'b0;
    hi    = int'(lv[7:4]);
    lo    = int'(lv[3:0]);
    if (r || clr) begin
      n.v = 0;
    end else if (load) begin
      if (hi <= 9 && lo <= 9 && hi * 10 + lo < modulus) n.v = hi * 10 + lo;
      else n.err = 1'b1;
    end else if (en) begin
      if (DOWN && dir) begin
        if (s.v == 0) begin n.v = modulus - 1; n.co = 1'b1; end
        else n.v = s.v - 1;
      end else begin
        if (s.v == modulus - 1) begin n.v = 0; n.co = 1'b1; end
        else n.v = s.v + 1;
      end
    end
    return n;
  endfunction

  function automatic logic exp_tc(input mstate_t s, input int modulus, input logic en, input logic dir);
    if (DOWN && dir) return en && (s.v == 0);
    return en && (s.v == modulus - 1);
  endfunction

  mstate_t ms [4];
  bit      started = 1'b0;

  always @(posedge clk) begin
    ms[0]   <= mstep(ms[0], 60, rst, if60.clr, if60.load, if60.load_val, if60.en, if60.dir);
    ms[1]   <= mstep(ms[1], 24, rst, if24.clr, if24.load, if24.load_val, if24.en, if24.dir);
    ms[2]   <= mstep(ms[2], 60, rst, sec_if.clr, sec_if.load, sec_if.load_val, sec_if.en, sec_if.dir);
    ms[3]   <= mstep(ms[3], 60, rst, min_if.clr, min_if.load, min_if.load_val,
                     exp_tc(ms[2], 60, sec_if.en, sec_if.dir), min_if.dir);
    started <= 1'b1;
  end

  task automatic cmp(input int idx, input int modulus, input string nm,
                     input logic [7:0] d, input logic co, input logic tc, input logic err,
                     input logic en, input logic dir);
    chk({nm, "_data"},     {24'd0, d}, {24'd0, to_bcd8(ms[idx].v)});
    chk({nm, "_co"},       {31'd0, co}, {31'd0, ms[idx].co});
    chk({nm, "_load_err"}, {31'd0, err}, {31'd0, ms[idx].err});
    chk({nm, "_tc"},       {31'd0, tc}, {31'd0, exp_tc(ms[idx], modulus, en, dir)});
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, 60, "m60", if60.data, if60.co, if60.tc, if60.load_err, if60.en, if60.dir);
      cmp(1, 24, "m24", if24.data, if24.co, if24.tc, if24.load_err, if24.en, if24.dir);
      cmp(2, 60, "sec", sec_if.data, sec_if.co, sec_if.tc, sec_if.load_err, sec_if.en, sec_if.dir);
      cmp(3, 60, "min", min_if.data, min_if.co, min_if.tc, min_if.load_err,
          exp_tc(ms[2], 60, sec_if.en, sec_if.dir), min_if.dir);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load60(input logic [7:0] v);
    if60.load     = 1'b1;
    if60.load_val = v;
    tick();
    if60.load     = 1'b0;
  endtask

  int min_co_count;

  initial begin
    for (int i = 0; i < 4; i++) ms[i] = '0;
    rst = 1'b1;
    if60.en = 0;   if60.clr = 0;   if60.load = 0;   if60.load_val = 0;   if60.dir = 0;
    if24.en = 0;   if24.clr = 0;   if24.load = 0;   if24.load_val = 0;   if24.dir = 0;
    sec_if.en = 0; sec_if.clr = 0; sec_if.load = 0; sec_if.load_val = 0; sec_if.dir = 0;
    min_if.clr = 0; min_if.load = 0; min_if.load_val = 0; min_if.dir = 0;
    repeat (2) tick();
    chk("reset_data", {24'd0, if60.data}, 32'h00);
    chk("reset_co", {31'd0, if60.co}, 32'd0);
    chk("reset_err", {31'd0, if60.load_err}, 32'd0);
    rst = 1'b0;

    // Free-running mod 60 and mod 24
    if60.en = 1'b1;
    if24.en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1)  chk("up_first", {24'd0, if60.data}, 32'h01);
      if (k == 10) chk("up_digit_carry", {24'd0, if60.data}, 32'h10);
      if (k == 23) chk("m24_last", {24'd0, if24.data}, 32'h23);
      if (k == 24) begin
        chk("m24_wrap", {24'd0, if24.data}, 32'h00);
        chk("m24_wrap_co", {31'd0, if24.co}, 32'd1);
      end
      if (k == 59) begin
        chk("up_last", {24'd0, if60.data}, 32'h59);
        chk("up_last_tc", {31'd0, if60.tc}, 32'd1);
        chk("up_last_co", {31'd0, if60.co}, 32'd0);
      end
      if (k == 60) begin
        chk("up_wrap", {24'd0, if60.data}, 32'h00);
        chk("up_wrap_co", {31'd0, if60.co}, 32'd1);
      end
    end
    if60.en = 1'b0;
    if24.en = 1'b0;
    tick();
    chk("co_one_cycle", {31'd0, if60.co}, 32'd0);

    // Presets: valid, out of range, non-BCD digit
    load60(8'h45);
    chk("load_45", {24'd0, if60.data}, 32'h45);
    chk("load_45_err", {31'd0, if60.load_err}, 32'd0);
    load60(8'h60);
    chk("load_60_hold", {24'd0, if60.data}, 32'h45);
    chk("load_60_err", {31'd0, if60.load_err}, 32'd1);
    tick();
    chk("load_err_clears", {31'd0, if60.load_err}, 32'd0);
    load60(8'h3A);
    chk("load_3a_hold", {24'd0, if60.data}, 32'h45);
    chk("load_3a_err", {31'd0, if60.load_err}, 32'd1);

    // clr / load / rst in the wrap cycle
    load60(8'h59);
    if60.en  = 1'b1;
    if60.clr = 1'b1;
    #1;
    chk("tc_ignores_clr", {31'd0, if60.tc}, 32'd1);
    tick();
    if60.en  = 1'b0;
    if60.clr = 1'b0;
    chk("clr_wrap_data", {24'd0, if60.data}, 32'h00);
    chk("clr_wrap_co", {31'd0, if60.co}, 32'd0);
    load60(8'h59);
    if60.en = 1'b1;
    load60(8'h12);
    if60.en = 1'b0;
    chk("load_wrap_data", {24'd0, if60.data}, 32'h12);
    chk("load_wrap_co", {31'd0, if60.co}, 32'd0);
    load60(8'h59);
    if60.en = 1'b1;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    if60.en = 1'b0;
    chk("rst_wrap_data", {24'd0, if60.data}, 32'h00);
    chk("rst_wrap_co", {31'd0, if60.co}, 32'd0);

`ifdef BCD_DOWN_EN
    load60(8'h01);
    if60.dir = 1'b1;
    if60.en  = 1'b1;
    tick();
    chk("down_0", {24'd0, if60.data}, 32'h00);
    chk("down_0_tc", {31'd0, if60.tc}, 32'd1);
    tick();
    chk("down_wrap", {24'd0, if60.data}, 32'h59);
    chk("down_wrap_co", {31'd0, if60.co}, 32'd1);
    tick();
    chk("down_58", {24'd0, if60.data}, 32'h58);
    chk("down_58_co", {31'd0, if60.co}, 32'd0);
`else
    load60(8'h01);
    if60.dir = 1'b1;
    if60.en  = 1'b1;
    tick();
    chk("dir_ignored", {24'd0, if60.data}, 32'h02);
`endif
    if60.en  = 1'b0;
    if60.dir = 1'b0;
    tick();

    // Cascaded minutes:seconds over a full hour
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sec_if.en    = 1'b1;
    min_co_count = 0;
    for (int k = 1; k <= 3600; k++) begin
      tick();
      if (min_if.co === 1'b1) min_co_count++;
      if (k == 60) chk("cascade_1min", {16'd0, min_if.data, sec_if.data}, 32'h0100);
      if (k == 3599) begin
        chk("cascade_5959", {16'd0, min_if.data, sec_if.data}, 32'h5959);
        chk("cascade_min_tc", {31'd0, min_if.tc}, 32'd1);
      end
      if (k == 3600) begin
        chk("cascade_0000", {16'd0, min_if.data, sec_if.data}, 32'h0000);
        chk("cascade_min_co", {31'd0, min_if.co}, 32'd1);
      end
    end
    sec_if.en = 1'b0;
    tick();
    chk("cascade_min_co_once", min_co_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised multi-digit BCD modulo counter, the successor to the fixed two-digit mod-60 counter in the SEG display designs. It counts in packed BCD up to a compile-time modulus (seconds, minutes, hours, and similar), can be preset, and can optionally count down. A registered wrap pulse plus a combinational terminal-count output let instances cascade without a one-cycle lag. It sits between the tick/prescaler logic and the 7-segment digit mux.

## Interface
Parameters:
- `DIGITS`, 2: number of BCD digits, legal range 1–4.
- `MODULUS`, 60: count modulus in binary. Legal range is 2 to 10^DIGITS. Count range is 0 to MODULUS-1.

Ports:
- `clk` input 1: single clock for all state.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: count-step enable, one step per cycle while high.
- `clr` input 1: synchronous clear to zero.
- `load` input 1: synchronous preset from `load_val`.
- `load_val` input 4*DIGITS: packed BCD preset value; digit 0 is in bits [3:0].
- `dir` input 1: 0 counts up, 1 counts down. Used only with `BCD_DOWN_EN`.
- `data` output 4*DIGITS: packed BCD count, registered.
- `co` output 1: registered wrap pulse.
- `tc` output 1: combinational terminal count.
- `load_err` output 1: registered one-cycle flag for a rejected preset.

## Operation
- Priority per cycle: `rst` > `clr` > `load` > `en` > hold.
- Reset: `data`=0, `co`=0, `load_err`=0.
- `clr`:
  - `data`=0, `co`=0, `load_err`=0.
  - `load` and `en` are ignored that cycle.
- `load`, valid `load_val` (every digit ≤ 9 and decimal value < MODULUS):
  - `data`=`load_val`, `co`=0, `load_err`=0.
- `load`, invalid `load_val`:
  - `data` unchanged, `load_err`=1 for one cycle, `co`=0.
- `en`, up direction:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - At value MODULUS-1, `data` becomes 0 and `co`=1.
- `en`, down direction:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - At value 0, `data` becomes the BCD encoding of MODULUS-1 and `co`=1.
- `co` is 1 only on a wrap step. In every other cycle, including `en`=0 cycles, `co`=0.
- `load_err` is 0 in every cycle that is not a rejected load.
- `tc` = `en` & (up ? `data`==MODULUS-1 : `data`==0).
  - `tc` does not depend on `clr`, `load` or `rst`.
  - Cascade by driving the next stage's `en` from this stage's `tc`.
- Arithmetic is per-digit 4-bit BCD; no binary-to-BCD conversion is used. The MODULUS-1 BCD constant is computed at elaboration.
- Illegal parameters are not reported: a MODULUS outside the legal range for DIGITS gives undefined behaviour.

## Timing
- All outputs except `tc` are registered, and each updates on the `clk` rising edge following the qualifying input cycle.
- `co` is high during the first cycle in which `data` shows the wrapped value, with 1-cycle latency from the wrapping `en`.
- `tc` is high in the same cycle as the `en` that will wrap, with zero latency. Use it for same-edge cascading.
- `rst`, `clr` or `load` asserted in the wrap cycle suppresses both the wrap and `co`.
- `dir` is sampled only in cycles with `en`=1. Changing `dir` between cycles is legal and has no extra effect.
- `en` held high steps every cycle; there is no internal prescaler.

## Configuration
- Macro: `BCD_DOWN_EN`.
- Defined:
  - `dir` selects up or down counting as described in Operation.
  - `tc` follows `dir`.
- Undefined:
  - `dir` is ignored and the block counts up only.
  - `tc` = `en` & (`data`==MODULUS-1).
  - The down-count/borrow logic is not synthesised.
  - The `dir` port remains in the port list for pin compatibility.

## Test plan
- Run 1–6 use DIGITS=2, MODULUS=60; run 2 is repeated with DIGITS=2, MODULUS=24.
1. Reset release, then `en`=1 for 60 cycles:
   - `data` steps 0x00, 0x01 … 0x09, 0x10 … 0x59, 0x00.
   - `co`=1 only in the cycle showing 0x00.
   - `tc`=1 only while `data`=0x59.
2. Reset release, then `en`=1 for 24 cycles with DIGITS=2, MODULUS=24:
   - `data` steps 0x00 … 0x23, then 0x00.
   - `co`=1 only in the cycle showing 0x00.
3. `load` with `load_val`=0x45 → `data`=0x45, `load_err`=0.
   - `load_val`=0x60 → `data` stays 0x45, `load_err`=1 for one cycle.
   - `load_val`=0x3A → `data` stays 0x45, `load_err`=1 for one cycle.
4. With `BCD_DOWN_EN` defined, `dir`=1, `en`=1 starting at 0x01 → `data` 0x00, then 0x59 with `co`=1, then 0x58.
   - `tc`=1 while `data`=0x00.
5. `data`=0x59 and `en`=1 in the same cycle as `clr`=1 → `data`=0x00, `co`=0.
   - Repeat with `load`=1 and `load_val`=0x12 instead of `clr` → `data`=0x12, `co`=0.
6. Two instances cascaded (seconds `tc` drives the minutes stage's `en`), seconds `en` held high for 3600 cycles → minutes/seconds wrap from 59:59 to 00:00.
   - Minutes `co`=1 exactly once, in the cycle showing 00:00.
